// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of one single-port RAM. It supports a bounded burst
// lock, a registered RAM command stage and a read-return pipeline with 2-cycle latency.
module ram_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int MAX_BURST     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     we0,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic                     lock0,
    output logic                     gnt0,
    output logic                     rvalid0,
    output logic [DATA_WIDTH-1:0]    rdata0,
    input  logic                     req1,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    input  logic                     lock1,
    output logic                     gnt1,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    owner_e                   owner_q;
    logic [7:0]               burst_cnt_q;
    logic                     last_winner_q;
    logic                     ram_wen_q;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0]    ram_din_q;
    logic                     tag_valid_q;
    logic                     tag_port_q;
    logic                     rvalid0_q, rvalid1_q;
    logic [DATA_WIDTH-1:0]    rdata0_q, rdata1_q;

    logic                     owner_active, owner_port;
    logic [1:0]               req_v;
    logic                     gnt_any, gnt_port;
    logic                     sel_we, sel_lock;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;

    assign owner_active = (owner_q != OWN_NONE);
    assign owner_port   = (owner_q == OWN_P1);
    assign req_v        = {req1, req0};

    // A saturated owner only yields when the other port is actually waiting.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt_any  = 1'b0;
        gnt_port = 1'b0;
        if (owner_active && req_v[owner_port]) begin
            gnt_any = 1'b1;
            if (burst_cnt_q == MAX_CNT && req_v[!owner_port]) begin
                gnt_port = !owner_port;
            end else begin
                gnt_port = owner_port;
            end
        end else if (req0 && req1) begin
            gnt_any  = 1'b1;
            gnt_port = !last_winner_q;
        end else if (req0 || req1) begin
            gnt_any  = 1'b1;
            gnt_port = req1;
        end
    end

    assign gnt0      = gnt_any && !gnt_port;
    assign gnt1      = gnt_any && gnt_port;
    assign sel_we    = gnt_port ? we1    : we0;
    assign sel_lock  = gnt_port ? lock1  : lock0;
    assign sel_addr  = gnt_port ? addr1  : addr0;
    assign sel_wdata = gnt_port ? wdata1 : wdata0;

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= OWN_NONE;
            burst_cnt_q   <= 8'd0;
            last_winner_q <= 1'b1;
            ram_wen_q     <= 1'b0;
            ram_addr_q    <= '0;
            ram_din_q     <= '0;
            tag_valid_q   <= 1'b0;
            tag_port_q    <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            // A grant to the current owner extends the burst, and a grant to the other port re-arms it.
            if (gnt_any && sel_lock) begin
                if (owner_active && gnt_port == owner_port) begin
                    if (burst_cnt_q != MAX_CNT) begin
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                    end
                end else begin
                    owner_q     <= gnt_port ? OWN_P1 : OWN_P0;
                    burst_cnt_q <= 8'd1;
                end
            end else begin
                owner_q     <= OWN_NONE;
                burst_cnt_q <= 8'd0;
            end

            if (gnt_any) begin
                last_winner_q <= gnt_port;
                ram_wen_q     <= sel_we;
                ram_addr_q    <= sel_addr;
                ram_din_q     <= sel_wdata;
            end else begin
                ram_wen_q     <= 1'b0;
            end

            tag_valid_q <= gnt_any && !sel_we;
            tag_port_q  <= gnt_port;

            rvalid0_q <= tag_valid_q && !tag_port_q;
            rvalid1_q <= tag_valid_q && tag_port_q;
            if (tag_valid_q && !tag_port_q) begin
                rdata0_q <= ram_dataOut;
            end
            if (tag_valid_q && tag_port_q) begin
                rdata1_q <= ram_dataOut;
            end
        end
    end

    assign ram_wEn    = ram_wen_q;
    assign ram_addr   = ram_addr_q;
    assign ram_dataIn = ram_din_q;
    assign rvalid0    = rvalid0_q;
    assign rvalid1    = rvalid1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, hand sequences for burst/reset corners,
// and randomized traffic against a transaction-level reference model.
module tb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn, ram_dataOut;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    // Single-port RAM sampled on the falling edge, with a 1-cycle read.
    logic [DW-1:0] mem [0:4095];
    always @(negedge clk) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        else         ram_dataOut   <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ctl = {req0, we0, lock0, req1, we1, lock1}
    task automatic set_in(input logic [5:0] ctl, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        {req0, we0, lock0, req1, we1, lock1} = ctl;
        addr0 = a0; wdata0 = d0; addr1 = a1; wdata1 = d1;
    endtask

    task automatic idle();
        set_in(6'b000_000, '0, '0, '0, '0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ex = {gnt0, gnt1, ram_wEn, rvalid0, rvalid1}
    typedef struct {
        logic [5:0]    ctl;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a1;
        logic [4:0]    ex;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] erd;
    } vec_t;

    vec_t tbl [13];

    // Reference model state: arbitration history, expected RAM command, memory contents, pending returns.
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } ret_t;

    int            m_owner, m_burst, m_last, cyc;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_rd [2];
    logic [DW-1:0] mm [0:4095];
    ret_t          pend [$];

    logic          p_act [2], p_we [2], p_lock [2], lock_mode [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];

    task automatic model_reset();
        m_owner = -1; m_burst = 0; m_last = 1; cyc = 0;
        m_wen = 1'b0; m_addr = '0; m_din = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        pend.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g;
        int cnt;
        logic ev [2];
        bit   exp_g1;

        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'hA000_0000 | DW'(i);
            mm[i]  = 32'hA000_0000 | DW'(i);
        end
        mem[12'h010] = 32'hDEADBEEF;

        //          ctl          a0       d0            a1       ex        eaddr    erd
        tbl[0]  = '{6'b100_000, 12'h010, 32'h0,        12'h000, 5'b10000, 12'h000, 32'h0};
        tbl[1]  = '{6'b000_000, 12'h000, 32'h0,        12'h000, 5'b00000, 12'h010, 32'h0};
        tbl[2]  = '{6'b000_000, 12'h000, 32'h0,        12'h000, 5'b00010, 12'h010, 32'hDEADBEEF};
        tbl[3]  = '{6'b110_000, 12'h020, 32'h12345678, 12'h000, 5'b10000, 12'h010, 32'h0};
        tbl[4]  = '{6'b100_000, 12'h020, 32'h0,        12'h000, 5'b10100, 12'h020, 32'h0};
        tbl[5]  = '{6'b000_000, 12'h000, 32'h0,        12'h000, 5'b00000, 12'h020, 32'h0};
        tbl[6]  = '{6'b000_000, 12'h000, 32'h0,        12'h000, 5'b00010, 12'h020, 32'h12345678};
        tbl[7]  = '{6'b100_100, 12'h030, 32'h0,        12'h031, 5'b01000, 12'h020, 32'h0};
        tbl[8]  = '{6'b100_100, 12'h030, 32'h0,        12'h031, 5'b10000, 12'h031, 32'h0};
        tbl[9]  = '{6'b100_100, 12'h030, 32'h0,        12'h031, 5'b01001, 12'h030, 32'hA0000031};
        tbl[10] = '{6'b100_100, 12'h030, 32'h0,        12'h031, 5'b10010, 12'h031, 32'hA0000030};
        tbl[11] = '{6'b000_000, 12'h000, 32'h0,        12'h000, 5'b00001, 12'h030, 32'hA0000031};
        tbl[12] = '{6'b000_000, 12'h000, 32'h0,        12'h000, 5'b00010, 12'h030, 32'hA0000030};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_wen",  ram_wEn,    1'b0);
        check("rst_addr", ram_addr,   12'h000);
        check("rst_din",  ram_dataIn, 32'h0);
        check("rst_rv",   {rvalid0, rvalid1}, 2'b00);
        check("rst_rd0",  rdata0, 32'h0);
        check("rst_rd1",  rdata1, 32'h0);
        check("rst_gnt",  {gnt0, gnt1}, 2'b00);
        next_cycle();

        // Directed table: single read, write-then-read, alternating reads
        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].ctl, tbl[i].a0, tbl[i].d0, tbl[i].a1, 32'h0);
            @(negedge clk);
            check($sformatf("tbl%0d_gnt0", i),  gnt0,     tbl[i].ex[4]);
            check($sformatf("tbl%0d_gnt1", i),  gnt1,     tbl[i].ex[3]);
            check($sformatf("tbl%0d_wen", i),   ram_wEn,  tbl[i].ex[2]);
            check($sformatf("tbl%0d_addr", i),  ram_addr, tbl[i].eaddr);
            check($sformatf("tbl%0d_rv0", i),   rvalid0,  tbl[i].ex[1]);
            check($sformatf("tbl%0d_rv1", i),   rvalid1,  tbl[i].ex[0]);
            if (tbl[i].ex[1]) check($sformatf("tbl%0d_rd0", i), rdata0, tbl[i].erd);
            if (tbl[i].ex[0]) check($sformatf("tbl%0d_rd1", i), rdata1, tbl[i].erd);
            next_cycle();
        end

        // Bounded burst: port 1 locked, port 0 waiting
        do_reset();
        set_in(6'b100_101, 12'h040, 32'h0, 12'h041, 32'h0);
        for (int i = 0; i < 19; i++) begin
            exp_g1 = !(i == 0 || i == 9 || i == 18);
            @(negedge clk);
            check($sformatf("burst%0d_gnt1", i), gnt1, exp_g1);
            check($sformatf("burst%0d_gnt0", i), gnt0, !exp_g1);
            next_cycle();
        end

        // Lock with no competitor runs past MAX_BURST, then yields at once to a newcomer
        do_reset();
        set_in(6'b000_101, 12'h000, 32'h0, 12'h042, 32'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt1 && !gnt0) cnt++;
            next_cycle();
        end
        check("solo_lock_count", cnt, 20);
        set_in(6'b100_101, 12'h043, 32'h0, 12'h042, 32'h0);
        @(negedge clk);
        check("solo_sat_yield_gnt0", gnt0, 1'b1);
        next_cycle();

        // Async reset: pending write command cleared immediately
        do_reset();
        set_in(6'b110_000, 12'h060, 32'h55, 12'h000, 32'h0);
        @(negedge clk);
        check("rstw_gnt0", gnt0, 1'b1);
        next_cycle();
        check("rstw_wen_before", ram_wEn, 1'b1);
        reset = 1'b1;
        idle();
        #1;
        check("rstw_wen_after", ram_wEn, 1'b0);
        next_cycle();
        reset = 1'b0;

        // Async reset the cycle after a read grant: the read return is dropped
        set_in(6'b100_000, 12'h010, 32'h0, 12'h000, 32'h0);
        @(negedge clk);
        check("rstr_gnt0", gnt0, 1'b1);
        next_cycle();
        check("rstr_addr_before", ram_addr, 12'h010);
        reset = 1'b1;
        idle();
        #1;
        check("rstr_addr_after", ram_addr, 12'h000);
        check("rstr_wen_after", ram_wEn, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rstr_rv%0d", i), {rvalid0, rvalid1}, 2'b00);
            next_cycle();
            if (i == 1) reset = 1'b0;
        end
        set_in(6'b100_100, 12'h011, 32'h0, 12'h012, 32'h0);
        @(negedge clk);
        check("rstr_first_gnt0", gnt0, 1'b1);
        check("rstr_first_gnt1", gnt1, 1'b0);
        next_cycle();

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        p_act[0] = 1'b0; p_act[1] = 1'b0;
        lock_mode[0] = 1'b0; lock_mode[1] = 1'b1;
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 31) == 0) lock_mode[p] = !lock_mode[p];
                if (!p_act[p] && $urandom_range(0, 3) != 0) begin
                    p_act[p]  = 1'b1;
                    p_we[p]   = ($urandom_range(0, 2) == 0);
                    p_addr[p] = 12'h100 + 12'($urandom_range(0, 7));
                    p_data[p] = $urandom;
                    p_lock[p] = lock_mode[p];
                end
            end
            set_in({p_act[0], p_we[0], p_lock[0], p_act[1], p_we[1], p_lock[1]},
                   p_addr[0], p_data[0], p_addr[1], p_data[1]);
            @(negedge clk);

            g = -1;
            if (m_owner >= 0 && p_act[m_owner]) begin
                if (m_burst < MB)           g = m_owner;
                else if (p_act[1-m_owner])  g = 1 - m_owner;
                else                        g = m_owner;
            end else if (p_act[0] && p_act[1]) g = 1 - m_last;
            else if (p_act[0])                 g = 0;
            else if (p_act[1])                 g = 1;

            ev[0] = 1'b0; ev[1] = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ev[pend[0].port]   = 1'b1;
                m_rd[pend[0].port] = pend[0].data;
                void'(pend.pop_front());
            end

            check("rnd_gnt0", gnt0, (g == 0));
            check("rnd_gnt1", gnt1, (g == 1));
            check("rnd_wen",  ram_wEn, m_wen);
            check("rnd_addr", ram_addr, m_addr);
            check("rnd_din",  ram_dataIn, m_din);
            check("rnd_rv0",  rvalid0, ev[0]);
            check("rnd_rv1",  rvalid1, ev[1]);
            check("rnd_rd0",  rdata0, m_rd[0]);
            check("rnd_rd1",  rdata1, m_rd[1]);

            if (g < 0) begin
                m_wen = 1'b0;
                m_owner = -1; m_burst = 0;
            end else begin
                m_wen  = p_we[g];
                m_addr = p_addr[g];
                m_din  = p_data[g];
                if (p_we[g]) mm[p_addr[g]] = p_data[g];
                else         pend.push_back('{cyc + 2, g, mm[p_addr[g]]});
                if (g == m_owner && p_lock[g]) begin
                    m_burst = (m_burst < MB) ? m_burst + 1 : MB;
                end else if (p_lock[g]) begin
                    m_owner = g; m_burst = 1;
                end else begin
                    m_owner = -1; m_burst = 0;
                end
                m_last   = g;
                p_act[g] = 1'b0;
            end
            cyc++;
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
